// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared state encoding and default sizing for the FIFO round-robin scheduler.
package fifo_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ERROR = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_Q      = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_RESUME_DLY = 3;

    // RESUME_DLY is limited to 1..15, so a 4-bit down-counter always suffices.
    localparam int RESUME_W       = 4;

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_Q = DEF_NUM_Q,
    parameter int SEL_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [NUM_Q-1:0] gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NUM_Q; i++) begin
            idx = SEL_W'((int'(last_grant) + i) % NUM_Q);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains NUM_Q FIFOs into one egress port with round-robin arbitration,
// almost-full boost, back-pressure pause and sticky error halt.
//
//  state    | meaning
//  ---------+------------------------------------------------------
//  ST_IDLE  | scheduler disabled, no pops
//  ST_RUN   | arbitrating, one pop per cycle at most
//  ST_PAUSE | downstream almost full, waiting RESUME_DLY quiet cycles
//  ST_ERROR | downstream error seen, halted until RESET
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_Q      = DEF_NUM_Q,
    parameter int SEL_W      = $clog2(NUM_Q),
    parameter int RESUME_DLY = DEF_RESUME_DLY,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [NUM_Q-1:0] FIFO_EMPTY,
    input  logic [NUM_Q-1:0] FIFO_ALMOST_FULL,
    input  logic             DEST_ALMOST_FULL,
    input  logic             DEST_ERR,
    output logic [NUM_Q-1:0] POP,
    output logic [SEL_W-1:0] SEL,
    output logic             VALID_OUT,
    output logic [1:0]       STATE,
    output logic             ERR,
    output logic [CNT_W-1:0] POP_COUNT
);

    sched_state_e         state;
    logic [SEL_W-1:0]     last_grant;
    logic [RESUME_W-1:0]  resume_cnt;

    logic [NUM_Q-1:0]     eligible;
    logic [NUM_Q-1:0]     boost_req;
    logic [NUM_Q-1:0]     boost_gnt;
    logic [NUM_Q-1:0]     norm_gnt;
    logic [SEL_W-1:0]     boost_idx;
    logic [SEL_W-1:0]     norm_idx;
    logic                 boost_any;
    logic                 norm_any;
    logic                 stay_run;

    // A FIFO popped last cycle may still show stale non-empty; skip it once.
    assign eligible  = ~FIFO_EMPTY & ~POP;
    assign boost_req = eligible & FIFO_ALMOST_FULL;
    assign stay_run  = (state == ST_RUN) && ENABLE && !DEST_ALMOST_FULL && !DEST_ERR;
    assign STATE     = state;

    rr_arbiter #(.NUM_Q(NUM_Q), .SEL_W(SEL_W)) u_arb_boost (
        .req        (boost_req),
        .last_grant (last_grant),
        .gnt_onehot (boost_gnt),
        .gnt_idx    (boost_idx),
        .any        (boost_any)
    );

    rr_arbiter #(.NUM_Q(NUM_Q), .SEL_W(SEL_W)) u_arb_norm (
        .req        (eligible),
        .last_grant (last_grant),
        .gnt_onehot (norm_gnt),
        .gnt_idx    (norm_idx),
        .any        (norm_any)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            POP        <= '0;
            VALID_OUT  <= 1'b0;
            SEL        <= '0;
            ERR        <= 1'b0;
            POP_COUNT  <= '0;
            last_grant <= SEL_W'(NUM_Q - 1);
            resume_cnt <= '0;
        end else begin
            POP <= '0;

            // While POP is high, last_grant is exactly the popped index.
            if (DEST_ERR || state == ST_ERROR) begin
                VALID_OUT <= 1'b0;
            end else begin
                VALID_OUT <= |POP;
                if (|POP) begin
                    SEL <= last_grant;
                end
            end

            if (stay_run && (boost_any || norm_any)) begin
                POP        <= boost_any ? boost_gnt : norm_gnt;
                last_grant <= boost_any ? boost_idx : norm_idx;
                POP_COUNT  <= POP_COUNT + 1'b1;
            end

            if (DEST_ERR) begin
                state <= ST_ERROR;
                ERR   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ENABLE) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!ENABLE) begin
                            state <= ST_IDLE;
                        end else if (DEST_ALMOST_FULL) begin
                            state      <= ST_PAUSE;
                            resume_cnt <= RESUME_W'(RESUME_DLY);
                        end
                    end
                    ST_PAUSE: begin
                        if (!ENABLE) begin
                            state <= ST_IDLE;
                        end else if (DEST_ALMOST_FULL) begin
                            resume_cnt <= RESUME_W'(RESUME_DLY);
                        end else if (resume_cnt <= RESUME_W'(1)) begin
                            state      <= ST_RUN;
                            resume_cnt <= '0;
                        end else begin
                            resume_cnt <= resume_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_ERROR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler; a 4-bit-count twin exercises counter wrap.
module tb_fifo_rr_scheduler;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [3:0]  FIFO_EMPTY;
    logic [3:0]  FIFO_ALMOST_FULL;
    logic        DEST_ALMOST_FULL;
    logic        DEST_ERR;

    logic [3:0]  POP;
    logic [1:0]  SEL;
    logic        VALID_OUT;
    logic [1:0]  STATE;
    logic        ERR;
    logic [15:0] POP_COUNT;

    logic [3:0]  pop_s;
    logic [1:0]  sel_s;
    logic        valid_s;
    logic [1:0]  state_s;
    logic        err_s;
    logic [3:0]  cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_rr_scheduler #(.NUM_Q(4), .SEL_W(2), .RESUME_DLY(3), .CNT_W(16)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ENABLE           (ENABLE),
        .FIFO_EMPTY       (FIFO_EMPTY),
        .FIFO_ALMOST_FULL (FIFO_ALMOST_FULL),
        .DEST_ALMOST_FULL (DEST_ALMOST_FULL),
        .DEST_ERR         (DEST_ERR),
        .POP              (POP),
        .SEL              (SEL),
        .VALID_OUT        (VALID_OUT),
        .STATE            (STATE),
        .ERR              (ERR),
        .POP_COUNT        (POP_COUNT)
    );

    fifo_rr_scheduler #(.NUM_Q(4), .SEL_W(2), .RESUME_DLY(3), .CNT_W(4)) dut_s (
        .CLK              (CLK),
        .RESET            (RESET),
        .ENABLE           (ENABLE),
        .FIFO_EMPTY       (FIFO_EMPTY),
        .FIFO_ALMOST_FULL (FIFO_ALMOST_FULL),
        .DEST_ALMOST_FULL (DEST_ALMOST_FULL),
        .DEST_ERR         (DEST_ERR),
        .POP              (pop_s),
        .SEL              (sel_s),
        .VALID_OUT        (valid_s),
        .STATE            (state_s),
        .ERR              (err_s),
        .POP_COUNT        (cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET            = 1'b1;
        ENABLE           = 1'b0;
        FIFO_EMPTY       = 4'b1111;
        FIFO_ALMOST_FULL = 4'b0000;
        DEST_ALMOST_FULL = 1'b0;
        DEST_ERR         = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET            = 1'b1;
        ENABLE           = 1'b1;
        FIFO_EMPTY       = 4'b0000;
        FIFO_ALMOST_FULL = 4'b0000;
        DEST_ALMOST_FULL = 1'b0;
        DEST_ERR         = 1'b0;
        tick();
        tick();
        n_cmp++; if (STATE !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", STATE); end
        n_cmp++; if (POP !== 4'b0000) begin n_bad++; $display("FAIL reset_pop got %b want 0000", POP); end
        n_cmp++; if (VALID_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", VALID_OUT); end
        n_cmp++; if (SEL !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", SEL); end
        n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", ERR); end
        n_cmp++; if (POP_COUNT !== 16'h0000) begin n_bad++; $display("FAIL reset_count got %h want 0000", POP_COUNT); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e_pop;
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b0000;
        tick();
        n_cmp++; if (STATE !== 2'd1) begin n_bad++; $display("FAIL rr_enter_run got %0d want 1", STATE); end
        n_cmp++; if (POP !== 4'b0000) begin n_bad++; $display("FAIL rr_first_pop got %b want 0000", POP); end
        for (int i = 0; i < 6; i++) begin
            tick();
            e_pop = 4'b0001 << (i % 4);
            n_cmp++; if (POP !== e_pop) begin n_bad++; $display("FAIL rr_pop[%0d] got %b want %b", i, POP, e_pop); end
            n_cmp++; if (VALID_OUT !== (i > 0)) begin n_bad++; $display("FAIL rr_valid[%0d] got %b want %b", i, VALID_OUT, (i > 0)); end
            n_cmp++; if (POP_COUNT !== 16'(i + 1)) begin n_bad++; $display("FAIL rr_count[%0d] got %0d want %0d", i, POP_COUNT, i + 1); end
            if (i > 0) begin
                n_cmp++; if (SEL !== 2'((i - 1) % 4)) begin n_bad++; $display("FAIL rr_sel[%0d] got %0d want %0d", i, SEL, (i - 1) % 4); end
            end
        end
        ENABLE = 1'b0;
        tick();
        n_cmp++; if (STATE !== 2'd0) begin n_bad++; $display("FAIL rr_to_idle got %0d want 0", STATE); end
        n_cmp++; if (POP !== 4'b0000) begin n_bad++; $display("FAIL rr_idle_pop got %b want 0000", POP); end
        n_cmp++; if (VALID_OUT !== 1'b1 || SEL !== 2'd1) begin n_bad++; $display("FAIL rr_tail_valid got %b/%0d want 1/1", VALID_OUT, SEL); end
        tick();
        n_cmp++; if (VALID_OUT !== 1'b0 || SEL !== 2'd1) begin n_bad++; $display("FAIL rr_sel_hold got %b/%0d want 0/1", VALID_OUT, SEL); end
    endtask

    task automatic test_holdoff();
        logic [3:0] e_pop;
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b1011;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            e_pop = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            n_cmp++; if (POP !== e_pop) begin n_bad++; $display("FAIL hold_pop[%0d] got %b want %b", i, POP, e_pop); end
            n_cmp++; if (VALID_OUT !== (i % 2 == 1)) begin n_bad++; $display("FAIL hold_valid[%0d] got %b want %b", i, VALID_OUT, (i % 2 == 1)); end
            n_cmp++; if (POP_COUNT !== 16'(i / 2 + 1)) begin n_bad++; $display("FAIL hold_count[%0d] got %0d want %0d", i, POP_COUNT, i / 2 + 1); end
            if (i > 0) begin
                n_cmp++; if (SEL !== 2'd2) begin n_bad++; $display("FAIL hold_sel[%0d] got %0d want 2", i, SEL); end
            end
        end
    endtask

    task automatic test_boost();
        logic [3:0] e_pop;
        do_reset();
        ENABLE           = 1'b1;
        FIFO_EMPTY       = 4'b0000;
        FIFO_ALMOST_FULL = 4'b1000;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            e_pop = (i % 2 == 0) ? 4'b1000 : 4'b0001;
            n_cmp++; if (POP !== e_pop) begin n_bad++; $display("FAIL boost_pop[%0d] got %b want %b", i, POP, e_pop); end
            n_cmp++; if (POP_COUNT !== 16'(i + 1)) begin n_bad++; $display("FAIL boost_count[%0d] got %0d want %0d", i, POP_COUNT, i + 1); end
        end
        do_reset();
        ENABLE           = 1'b1;
        FIFO_EMPTY       = 4'b0000;
        FIFO_ALMOST_FULL = 4'b0110;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            e_pop = (i % 2 == 0) ? 4'b0010 : 4'b0100;
            n_cmp++; if (POP !== e_pop) begin n_bad++; $display("FAIL boost2_pop[%0d] got %b want %b", i, POP, e_pop); end
        end
    endtask

    task automatic test_pause();
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b0000;
        tick();
        tick();
        n_cmp++; if (POP !== 4'b0001) begin n_bad++; $display("FAIL pause_pre_pop got %b want 0001", POP); end
        DEST_ALMOST_FULL = 1'b1;
        tick();
        n_cmp++; if (STATE !== 2'd2) begin n_bad++; $display("FAIL pause_enter got %0d want 2", STATE); end
        n_cmp++; if (POP !== 4'b0000) begin n_bad++; $display("FAIL pause_pop got %b want 0000", POP); end
        n_cmp++; if (VALID_OUT !== 1'b1 || SEL !== 2'd0) begin n_bad++; $display("FAIL pause_inflight got %b/%0d want 1/0", VALID_OUT, SEL); end
        DEST_ALMOST_FULL = 1'b0;
        tick();
        n_cmp++; if (STATE !== 2'd2 || VALID_OUT !== 1'b0) begin n_bad++; $display("FAIL pause_wait1 got %0d/%b want 2/0", STATE, VALID_OUT); end
        tick();
        n_cmp++; if (STATE !== 2'd2) begin n_bad++; $display("FAIL pause_wait2 got %0d want 2", STATE); end
        tick();
        n_cmp++; if (STATE !== 2'd1 || POP !== 4'b0000) begin n_bad++; $display("FAIL pause_resume got %0d/%b want 1/0000", STATE, POP); end
        tick();
        n_cmp++; if (POP !== 4'b0010) begin n_bad++; $display("FAIL pause_next_pop got %b want 0010", POP); end
        n_cmp++; if (POP_COUNT !== 16'd2) begin n_bad++; $display("FAIL pause_count got %0d want 2", POP_COUNT); end
        DEST_ALMOST_FULL = 1'b1;
        tick();
        DEST_ALMOST_FULL = 1'b0;
        tick();
        tick();
        DEST_ALMOST_FULL = 1'b1;
        tick();
        DEST_ALMOST_FULL = 1'b0;
        tick();
        tick();
        n_cmp++; if (STATE !== 2'd2) begin n_bad++; $display("FAIL pause_reload got %0d want 2", STATE); end
        tick();
        n_cmp++; if (STATE !== 2'd1) begin n_bad++; $display("FAIL pause_resume2 got %0d want 1", STATE); end
    endtask

    task automatic test_error();
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b0000;
        tick();
        tick();
        DEST_ERR = 1'b1;
        tick();
        n_cmp++; if (STATE !== 2'd3 || ERR !== 1'b1) begin n_bad++; $display("FAIL err_enter got %0d/%b want 3/1", STATE, ERR); end
        n_cmp++; if (POP !== 4'b0000 || VALID_OUT !== 1'b0) begin n_bad++; $display("FAIL err_outputs got %b/%b want 0000/0", POP, VALID_OUT); end
        n_cmp++; if (SEL !== 2'd0) begin n_bad++; $display("FAIL err_sel got %0d want 0", SEL); end
        DEST_ERR = 1'b0;
        tick();
        tick();
        n_cmp++; if (STATE !== 2'd3 || ERR !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %0d/%b want 3/1", STATE, ERR); end
        n_cmp++; if (POP !== 4'b0000 || POP_COUNT !== 16'd1) begin n_bad++; $display("FAIL err_no_pop got %b/%0d want 0000/1", POP, POP_COUNT); end
        #2;
        RESET = 1'b1;
        #1;
        n_cmp++; if (STATE !== 2'd0 || ERR !== 1'b0) begin n_bad++; $display("FAIL err_clear got %0d/%b want 0/0", STATE, ERR); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_count_wrap();
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b0000;
        repeat (16) tick();
        n_cmp++; if (cnt_s !== 4'hF) begin n_bad++; $display("FAIL wrap_allones got %h want f", cnt_s); end
        n_cmp++; if (POP_COUNT !== 16'h000F) begin n_bad++; $display("FAIL wrap_wide15 got %h want 000f", POP_COUNT); end
        tick();
        n_cmp++; if (cnt_s !== 4'h0) begin n_bad++; $display("FAIL wrap_zero got %h want 0", cnt_s); end
        n_cmp++; if (POP_COUNT !== 16'h0010) begin n_bad++; $display("FAIL wrap_wide16 got %h want 0010", POP_COUNT); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ENABLE     = 1'b1;
        FIFO_EMPTY = 4'b0000;
        repeat (15) tick();
        n_cmp++; if (cnt_s !== 4'hE) begin n_bad++; $display("FAIL arst_precount got %h want e", cnt_s); end
        n_cmp++; if (POP !== 4'b0010 || VALID_OUT !== 1'b1) begin n_bad++; $display("FAIL arst_burst got %b/%b want 0010/1", POP, VALID_OUT); end
        #2;
        RESET = 1'b1;
        #1;
        n_cmp++; if (POP !== 4'b0000 || VALID_OUT !== 1'b0) begin n_bad++; $display("FAIL arst_pop_valid got %b/%b want 0000/0", POP, VALID_OUT); end
        n_cmp++; if (STATE !== 2'd0 || SEL !== 2'd0 || ERR !== 1'b0) begin n_bad++; $display("FAIL arst_ctrl got %0d/%0d/%b want 0/0/0", STATE, SEL, ERR); end
        n_cmp++; if (POP_COUNT !== 16'h0000) begin n_bad++; $display("FAIL arst_count got %h want 0000", POP_COUNT); end
        n_cmp++; if (pop_s !== 4'b0000 || valid_s !== 1'b0 || cnt_s !== 4'h0) begin n_bad++; $display("FAIL arst_twin got %b/%b/%h want 0000/0/0", pop_s, valid_s, cnt_s); end
        n_cmp++; if (state_s !== 2'd0 || sel_s !== 2'd0 || err_s !== 1'b0) begin n_bad++; $display("FAIL arst_twin_ctrl got %0d/%0d/%b want 0/0/0", state_s, sel_s, err_s); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET            = 1'b1;
        ENABLE           = 1'b0;
        FIFO_EMPTY       = 4'b1111;
        FIFO_ALMOST_FULL = 4'b0000;
        DEST_ALMOST_FULL = 1'b0;
        DEST_ERR         = 1'b0;
        test_reset();
        test_round_robin();
        test_holdoff();
        test_boost();
        test_pause();
        test_error();
        test_count_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
